// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizing constants for the two-port SRAM arbiter.
// The optional SRAM_ARB_FIXED_PRIO_EN build switch lives in sram_arbiter_rr_arb2.
package sram_arbiter_pkg;

  // Access sequencer states: grant in IDLE, macro strobe in ACCESS, ack in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int RAM_BYTES   = 4096;
  localparam int BANKS       = 8;
  localparam int BANK_SEL_W  = 3;
  localparam int WORD_ADDR_W = 9;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus bundle for the SRAM arbiter: CPU port (p0) and
// Wishbone/DMA port (p1).
//
// Handshake: a requester raises pN_req with pN_we/pN_addr/pN_wdata and holds
// all four stable until it samples pN_ack = 1 (a one-cycle strobe). pN_rdata
// is valid only while pN_ack is high. After the ack the requester may drop
// pN_req or present the next request in the same cycle. Dropping pN_req
// before it has been granted cancels it with no side effect.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [7:0]        p0_wdata;
  logic              p0_ack;
  logic [7:0]        p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [7:0]        p1_wdata;
  logic              p1_ack;
  logic [7:0]        p1_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata
  );
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-way grant generator for the SRAM arbiter.
// Default build: round-robin, last_grant resets to 1 so port 0 wins first.
// With SRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins a contest.
module sram_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,   // a grant is being taken this cycle
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it asks; port 1 only when port 0 is quiet.
  assign gnt_id = ~req[0];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst_n, advance};
`else
  logic last_grant;

  // On a contest the port that was not served last wins; otherwise the lone requester.
  assign gnt_id = (req[0] & req[1]) ? ~last_grant : ~req[0];

  // Remember who was granted, updated on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && gnt_valid) begin
      last_grant <= gnt_id;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the 4 KiB byte-interleaved SRAM array
// (8 byte-wide macros, bank = addr[2:0], word = addr[11:3]).
// Sequence per access: IDLE (grant + latch) -> ACCESS (macro strobe) -> RESP (ack).
// Build option SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority (see rr_arb2).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RAM_BYTES = sram_arbiter_pkg::RAM_BYTES,
  parameter int BANKS     = sram_arbiter_pkg::BANKS
) (
  input  logic                   wb_clk_i,
  input  logic                   rst_n,
  sram_arbiter_if.slave          bus,
  output logic                   CEN_all,
  output logic [7:0]             WEN_all,
  output logic [WORD_ADDR_W-1:0] A_all,
  output logic [7:0]             D_all,
  output logic [BANKS-1:0]       GWEN,
  input  logic [8*BANKS-1:0]     Q,
  output state_t                 state_dbg
);

  localparam int SEL_W = $clog2(BANKS);

  state_t            state, state_nxt;
  logic              win_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_wdata;
  logic [7:0]        rdata0_q, rdata1_q;
  logic              gnt_valid, gnt_id;
  logic              ack0, ack1;
  logic              in_range;
  logic [SEL_W-1:0]  bank;
  logic [7:0]        q_sel;
  logic [7:0]        resp_data;

  sram_arbiter_rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst_n     (rst_n),
    .req       ({bus.p1_req, bus.p0_req}),
    .advance   (state == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign in_range  = 32'(lat_addr) < 32'(RAM_BYTES);
  assign bank      = lat_addr[SEL_W-1:0];
  assign q_sel     = Q[8*int'(bank) +: 8];
  // Writes and out-of-range reads answer zero.
  assign resp_data = (!lat_we && in_range) ? q_sel : 8'h00;

  // Macro address/data come straight from the latched request.
  assign A_all     = lat_addr[SEL_W +: WORD_ADDR_W];
  assign D_all     = lat_wdata;
  assign WEN_all   = 8'h00;
  assign state_dbg = state;

  assign bus.p0_ack   = ack0;
  assign bus.p1_ack   = ack1;
  // Winner sees live bank data during RESP; the other port keeps its last value.
  assign bus.p0_rdata = (state == RESP && !win_id) ? resp_data : rdata0_q;
  assign bus.p1_rdata = (state == RESP &&  win_id) ? resp_data : rdata1_q;

  // Sequencer state register.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winning request at the grant edge.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      win_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 8'h00;
    end else if (state == IDLE && gnt_valid) begin
      win_id    <= gnt_id;
      lat_we    <= gnt_id ? bus.p1_we    : bus.p0_we;
      lat_addr  <= gnt_id ? bus.p1_addr  : bus.p0_addr;
      lat_wdata <= gnt_id ? bus.p1_wdata : bus.p0_wdata;
    end
  end

  // Hold each port's last returned byte once its RESP cycle ends.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else if (state == RESP) begin
      if (win_id) begin
        rdata1_q <= resp_data;
      end else begin
        rdata0_q <= resp_data;
      end
    end
  end

  // Next state, macro strobes and acks.
  always_comb begin
    state_nxt = state;
    CEN_all   = 1'b1;
    GWEN      = '1;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        CEN_all = 1'b0;
        if (lat_we && in_range) begin
          GWEN[bank] = 1'b0;
        end
        state_nxt = RESP;
      end
      RESP: begin
        ack0      = ~win_id;
        ack1      = win_id;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
